// File: rtl/ecc_pkg.sv
// Shared ECC types and the codeword-to-data layout mapping used by the encoder and the decoder.
// Codeword layout: bit 0 overall parity, bit 2^i Hamming bit i+1, all other bits data in ascending order.
package ecc_pkg;

  localparam int ECC_CW_MAX   = 128;
  localparam int ECC_DATA_MAX = 120;

  typedef enum logic [1:0] {
    ECC_CLEAN  = 2'd0,
    ECC_CORR   = 2'd1,
    ECC_UNCORR = 2'd2
  } ecc_status_t;

  // Gather the non-power-of-two positions below cw_w; callers zero-extend and size-cast.
  function automatic logic [ECC_DATA_MAX-1:0] ecc_extract_data(
    input logic [ECC_CW_MAX-1:0] cw,
    input int                    cw_w
  );
    logic [ECC_DATA_MAX-1:0] d;
    int                      j;
    d = '0;
    j = 0;
    for (int k = 1; k < ECC_CW_MAX; k++) begin
      if ((k < cw_w) && ((k & (k - 32'sd1)) != 32'sd0) && (j < ECC_DATA_MAX)) begin
        d[j] = cw[k];
        j    = j + 32'sd1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational Hamming syndrome and overall parity of a SECDED codeword.
module ecc_syndrome_calc #(
  parameter int cw_width  = 72,
  parameter int syn_width = 7
) (
  input  logic [cw_width-1:0]  cw,
  output logic [syn_width-1:0] syn,
  output logic                 op
);

  // Syndrome bit j is the parity of all positions whose index has bit j set.
  always_comb begin
    syn = '0;
    for (int j = 0; j < syn_width; j++) begin
      for (int k = 1; k < cw_width; k++) begin
        if (((k >> j) & 32'sd1) != 32'sd0) begin
          syn[j] = syn[j] ^ cw[k];
        end else begin
          syn[j] = syn[j];
        end
      end
    end
  end

  assign op = ^cw;

endmodule

// File: rtl/ecc_decoder.sv
// Two-stage pipelined SECDED decoder with global stall and saturating event counters.
// Optional first-error log enabled by defining ECC_DEC_FIRST_ERR_LOG_EN.
module ecc_decoder
  import ecc_pkg::*;
#(
  parameter int data_bit_width      = 64,
  parameter int redundant_bit_width = 8,
  parameter int cnt_width           = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        dec_in_valid,
  output logic                                        dec_in_ready,
  input  logic [data_bit_width+redundant_bit_width-1:0] dec_data_in,
  output logic                                        dec_out_valid,
  input  logic                                        dec_out_ready,
  output logic [data_bit_width-1:0]                   dec_data_out,
  output logic                                        dec_err_corr,
  output logic                                        dec_err_uncorr,
  output logic [redundant_bit_width-1:0]              dec_syndrome,
  input  logic                                        cnt_clr,
  output logic [cnt_width-1:0]                        corr_cnt,
  output logic [cnt_width-1:0]                        uncorr_cnt
`ifdef ECC_DEC_FIRST_ERR_LOG_EN
  ,
  output logic                                        first_err_valid,
  output logic [redundant_bit_width-1:0]              first_err_syn
`endif
);

  localparam int CW_W  = data_bit_width + redundant_bit_width;
  localparam int SYN_W = redundant_bit_width - 1;
  localparam logic [CW_W-1:0]      ONE_CW  = {{(CW_W-1){1'b0}}, 1'b1};
  localparam logic [cnt_width-1:0] CNT_MAX = {cnt_width{1'b1}};

  logic                           adv_s;
  logic                           hs_s;
  logic                           s1_valid_r;
  logic [CW_W-1:0]                s1_cw_r;
  logic [SYN_W-1:0]               syn_s;
  logic                           op_s;
  ecc_status_t                    status_s;
  logic [CW_W-1:0]                flip_s;
  logic [data_bit_width-1:0]      data_s;
  logic                           out_valid_r;
  logic [data_bit_width-1:0]      data_r;
  logic                           corr_r;
  logic                           uncorr_r;
  logic [redundant_bit_width-1:0] syn_r;
  logic [cnt_width-1:0]           corr_cnt_r;
  logic [cnt_width-1:0]           uncorr_cnt_r;

  assign adv_s        = !out_valid_r || dec_out_ready;
  assign hs_s         = out_valid_r && dec_out_ready;
  assign dec_in_ready = adv_s;

  // Stage 1: capture the incoming codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_cw_r    <= '0;
    end else if (adv_s) begin
      s1_valid_r <= dec_in_valid;
      if (dec_in_valid) begin
        s1_cw_r <= dec_data_in;
      end
    end
  end

  ecc_syndrome_calc #(
    .cw_width  (CW_W),
    .syn_width (SYN_W)
  ) u_syn (
    .cw  (s1_cw_r),
    .syn (syn_s),
    .op  (op_s)
  );

  // Classify the word; a nonzero in-range syndrome with odd parity names the flipped bit.
  always_comb begin
    status_s = ECC_CLEAN;
    flip_s   = '0;
    if (op_s) begin
      if (syn_s == '0) begin
        status_s = ECC_CORR;
      end else if (32'(syn_s) < CW_W) begin
        status_s = ECC_CORR;
        flip_s   = ONE_CW << syn_s;
      end else begin
        status_s = ECC_UNCORR;
      end
    end else begin
      if (syn_s == '0) begin
        status_s = ECC_CLEAN;
      end else begin
        status_s = ECC_UNCORR;
      end
    end
  end

  assign data_s = data_bit_width'(ecc_extract_data(ECC_CW_MAX'(s1_cw_r ^ flip_s), CW_W));

  // Stage 2: register corrected data, status and syndrome.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      data_r      <= '0;
      corr_r      <= 1'b0;
      uncorr_r    <= 1'b0;
      syn_r       <= '0;
    end else if (adv_s) begin
      out_valid_r <= s1_valid_r;
      data_r      <= data_s;
      corr_r      <= (status_s == ECC_CORR);
      uncorr_r    <= (status_s == ECC_UNCORR);
      syn_r       <= {syn_s, op_s};
    end
  end

  // Saturating event counters; clear wins over a coincident event.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt_r   <= '0;
      uncorr_cnt_r <= '0;
    end else if (hs_s) begin
      if (corr_r && (corr_cnt_r != CNT_MAX)) begin
        corr_cnt_r <= corr_cnt_r + {{(cnt_width-1){1'b0}}, 1'b1};
      end
      if (uncorr_r && (uncorr_cnt_r != CNT_MAX)) begin
        uncorr_cnt_r <= uncorr_cnt_r + {{(cnt_width-1){1'b0}}, 1'b1};
      end
    end
  end

  assign dec_out_valid  = out_valid_r;
  assign dec_data_out   = data_r;
  assign dec_err_corr   = corr_r;
  assign dec_err_uncorr = uncorr_r;
  assign dec_syndrome   = syn_r;
  assign corr_cnt       = corr_cnt_r;
  assign uncorr_cnt     = uncorr_cnt_r;

`ifdef ECC_DEC_FIRST_ERR_LOG_EN
  logic                           log_valid_r;
  logic [redundant_bit_width-1:0] log_syn_r;

  // Keep only the first erroneous word's syndrome until cleared.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      log_valid_r <= 1'b0;
      log_syn_r   <= '0;
    end else if (hs_s && (corr_r || uncorr_r) && !log_valid_r) begin
      log_valid_r <= 1'b1;
      log_syn_r   <= syn_r;
    end
  end

  assign first_err_valid = log_valid_r;
  assign first_err_syn   = log_syn_r;
`endif

endmodule

// File: tb/tb_ecc_decoder.sv
// Self-checking bench for ecc_decoder: golden vectors, backpressure, counters, reset and random traffic.
module tb_ecc_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_in_valid;
  logic        dec_in_ready;
  logic [71:0] dec_data_in;
  logic        dec_out_valid;
  logic        dec_out_ready;
  logic [63:0] dec_data_out;
  logic        dec_err_corr;
  logic        dec_err_uncorr;
  logic [7:0]  dec_syndrome;
  logic        cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
  logic        d2_in_ready, d2_out_valid, d2_err_corr, d2_err_uncorr;
  logic [63:0] d2_data_out;
  logic [7:0]  d2_syndrome;
  logic [1:0]  d2_corr_cnt, d2_uncorr_cnt;
`ifdef ECC_DEC_FIRST_ERR_LOG_EN
  logic        fe_valid, d2_fe_valid;
  logic [7:0]  fe_syn, d2_fe_syn;
`endif

  always #5 clk = ~clk;

  ecc_decoder dut (
    .clk(clk), .rst(rst), .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready),
    .dec_data_in(dec_data_in), .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready),
    .dec_data_out(dec_data_out), .dec_err_corr(dec_err_corr), .dec_err_uncorr(dec_err_uncorr),
    .dec_syndrome(dec_syndrome), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`ifdef ECC_DEC_FIRST_ERR_LOG_EN
    , .first_err_valid(fe_valid), .first_err_syn(fe_syn)
`endif
  );

  ecc_decoder #(.cnt_width(2)) dut2 (
    .clk(clk), .rst(rst), .dec_in_valid(dec_in_valid), .dec_in_ready(d2_in_ready),
    .dec_data_in(dec_data_in), .dec_out_valid(d2_out_valid), .dec_out_ready(dec_out_ready),
    .dec_data_out(d2_data_out), .dec_err_corr(d2_err_corr), .dec_err_uncorr(d2_err_uncorr),
    .dec_syndrome(d2_syndrome), .cnt_clr(cnt_clr), .corr_cnt(d2_corr_cnt), .uncorr_cnt(d2_uncorr_cnt)
`ifdef ECC_DEC_FIRST_ERR_LOG_EN
    , .first_err_valid(d2_fe_valid), .first_err_syn(d2_fe_syn)
`endif
  );

  typedef struct packed {
    logic [63:0] data;
    logic        corr;
    logic        uncorr;
    logic [7:0]  syn;
  } out_t;

  typedef struct {
    logic [71:0] cw;
    logic [63:0] d;
    logic        c;
    logic        u;
    logic [7:0]  s;
    string       nm;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          corr_m = 0;
  int          uncorr_m = 0;
  logic [71:0] words_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_pow2(input int k);
    return (k & (k - 1)) == 0;
  endfunction

  // Hamming syndrome as the XOR of the indices of all set bits.
  function automatic logic [6:0] syn_of(input logic [71:0] cw);
    logic [6:0] s = 7'd0;
    for (int k = 0; k < 72; k++) if (cw[k]) s = s ^ 7'(k);
    return s;
  endfunction

  function automatic logic [63:0] extract(input logic [71:0] cw);
    logic [63:0] d = 64'd0;
    int j = 0;
    for (int k = 1; k < 72; k++) if (!is_pow2(k)) begin d[j] = cw[k]; j++; end
    return d;
  endfunction

  function automatic logic [71:0] enc(input logic [63:0] d);
    logic [71:0] cw = 72'd0;
    logic [6:0]  s;
    int j = 0;
    for (int k = 1; k < 72; k++) if (!is_pow2(k)) begin cw[k] = d[j]; j++; end
    s = syn_of(cw);
    for (int i = 0; i < 7; i++) cw[1 << i] = s[i];
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic out_t model(input logic [71:0] cw_in);
    out_t        r;
    logic [71:0] cw = cw_in;
    logic [6:0]  s  = syn_of(cw_in);
    logic        op = ^cw_in;
    r.corr = 1'b0;
    r.uncorr = 1'b0;
    if (op && (s < 7'd72)) begin
      r.corr = 1'b1;
      if (s != 7'd0) cw[s] = ~cw[s];
    end else if (op || (s != 7'd0)) begin
      r.uncorr = 1'b1;
    end
    r.data = extract(cw);
    r.syn  = {s, op};
    return r;
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic check_cnts(input string nm);
    chk({nm, " corr_cnt"}, corr_cnt, corr_m);
    chk({nm, " uncorr_cnt"}, uncorr_cnt, uncorr_m);
    chk({nm, " corr_cnt w2"}, d2_corr_cnt, sat3(corr_m));
    chk({nm, " uncorr_cnt w2"}, d2_uncorr_cnt, sat3(uncorr_m));
  endtask

  // One word through an idle pipe: latency, outputs, then counters after the handshake.
  task automatic apply_vec(input logic [71:0] cw, input logic [63:0] ed, input logic ec,
                           input logic eu, input logic [7:0] es, input logic clr, input string nm);
    dec_in_valid = 1'b1;
    dec_data_in = cw;
    dec_out_ready = 1'b1;
    step();
    dec_in_valid = 1'b0;
    chk({nm, " early valid"}, dec_out_valid, 1'b0);
    step();
    chk({nm, " valid"}, dec_out_valid, 1'b1);
    chk({nm, " data"}, dec_data_out, ed);
    chk({nm, " flags"}, {dec_err_corr, dec_err_uncorr}, {ec, eu});
    chk({nm, " syndrome"}, dec_syndrome, es);
    cnt_clr = clr;
    step();
    cnt_clr = 1'b0;
    if (clr) begin
      corr_m = 0;
      uncorr_m = 0;
    end else begin
      corr_m += int'(ec);
      uncorr_m += int'(eu);
    end
    check_cnts(nm);
  endtask

  // Streams words_q with a ready pattern; mode 0 stalls cycles 2..4, mode 1 is random.
  task automatic run_stream(input int mode, input string nm);
    out_t exp_q[$];
    out_t e;
    int sent = 0, got = 0, cyc = 0, stalls = 0;
    int n = words_q.size();
    while (got < n && cyc < 5000) begin
      dec_out_ready = (mode == 0) ? !(cyc >= 2 && cyc <= 4) : ($urandom_range(0, 3) != 0);
      dec_in_valid = (sent < n);
      dec_data_in = (sent < n) ? words_q[sent] : 72'd0;
      #1;
      chk({nm, " in_ready"}, dec_in_ready, !(dec_out_valid && !dec_out_ready));
      if (dec_out_valid) begin
        if (exp_q.size() == 0) begin
          chk({nm, " spurious valid"}, dec_out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          chk({nm, dec_out_ready ? " word" : " held word"},
              {dec_data_out, dec_err_corr, dec_err_uncorr, dec_syndrome}, e);
          if (dec_out_ready) begin
            void'(exp_q.pop_front());
            got++;
            corr_m += int'(e.corr);
            uncorr_m += int'(e.uncorr);
          end else begin
            stalls++;
          end
        end
      end
      if (dec_in_valid && dec_in_ready) begin
        exp_q.push_back(model(words_q[sent]));
        sent++;
      end
      step();
      cyc++;
    end
    dec_in_valid = 1'b0;
    dec_out_ready = 1'b1;
    chk({nm, " words out"}, got, n);
    if (mode == 0) chk({nm, " stall cycles"}, stalls, 3);
    check_cnts(nm);
  endtask

  initial begin
    logic [63:0] D;
    logic [71:0] base;
    vec_t        tbl[6];
    int          b1, b2, kind;

    D = 64'h0123_4567_89AB_CDEF;
    base = enc(D);
    tbl[0] = '{base,                                         D,          1'b0, 1'b0, 8'h00, "clean"};
    tbl[1] = '{base ^ (72'd1 << 5),                          D,          1'b1, 1'b0, 8'h0B, "single b5"};
    tbl[2] = '{base ^ (72'd1 << 3) ^ (72'd1 << 10),          D ^ 64'h21, 1'b0, 1'b1, 8'h12, "double b3 b10"};
    tbl[3] = '{base ^ 72'd1,                                 D,          1'b1, 1'b0, 8'h01, "parity b0"};
    tbl[4] = '{base ^ 72'd1 ^ (72'd1 << 8) ^ (72'd1 << 64),  D,          1'b0, 1'b1, 8'h91, "syn out of range"};
    tbl[5] = '{base ^ (72'd1 << 71),                         D,          1'b1, 1'b0, 8'h8F, "single b71"};

    rst = 1'b1;
    dec_in_valid = 1'b0;
    dec_data_in = 72'd0;
    dec_out_ready = 1'b1;
    cnt_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset valid", dec_out_valid, 1'b0);
    chk("reset outputs", {dec_data_out, dec_err_corr, dec_err_uncorr, dec_syndrome}, 74'd0);
    chk("reset in_ready", dec_in_ready, 1'b1);
    check_cnts("reset");

    for (int i = 0; i < 6; i++)
      apply_vec(tbl[i].cw, tbl[i].d, tbl[i].c, tbl[i].u, tbl[i].s, 1'b0, tbl[i].nm);

    apply_vec(enc(~D) ^ (72'd1 << 9),  ~D, 1'b1, 1'b0, {7'd9, 1'b1},  1'b0, "corr4");
    apply_vec(enc(~D) ^ (72'd1 << 33), ~D, 1'b1, 1'b0, {7'd33, 1'b1}, 1'b0, "corr5");
    chk("saturated corr_cnt w2", d2_corr_cnt, 2'd3);
    chk("unsaturated corr_cnt", corr_cnt, 16'd5);
    apply_vec(base ^ (72'd1 << 12), D, 1'b1, 1'b0, {7'd12, 1'b1}, 1'b1, "clr on handshake");

    words_q = {base, base ^ (72'd1 << 20), enc(~D) ^ (72'd1 << 7) ^ (72'd1 << 40),
               enc(64'h5555_AAAA_0F0F_F0F0)};
    run_stream(0, "backpressure");

    words_q = {};
    for (int i = 0; i < 200; i++) begin
      base = enc({$urandom, $urandom});
      kind = $urandom_range(0, 3);
      b1 = $urandom_range(0, 71);
      b2 = (b1 + $urandom_range(1, 71)) % 72;
      if (kind == 1) base[b1] = ~base[b1];
      if (kind == 2) begin
        base[b1] = ~base[b1];
        base[b2] = ~base[b2];
      end
      words_q.push_back(base);
    end
    run_stream(1, "random");

    dec_out_ready = 1'b0;
    dec_in_valid = 1'b1;
    dec_data_in = enc(D) ^ (72'd1 << 6);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dec_in_valid = 1'b0;
    corr_m = 0;
    uncorr_m = 0;
    chk("midreset valid", dec_out_valid, 1'b0);
    chk("midreset outputs", {dec_data_out, dec_err_corr, dec_err_uncorr, dec_syndrome}, 74'd0);
    chk("midreset in_ready", dec_in_ready, 1'b1);
    check_cnts("midreset");
    dec_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dropped in flight", dec_out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
